// File: rtl/region_binarize_5x5_pkg.sv
// Shared constants, window payload type and helpers for the region binarizer.
package region_bin_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned ROW_W      = 11;
  localparam int unsigned TOT_W      = 13;
  localparam int unsigned PROD_W     = 19;
  localparam int unsigned PIPE_LAT   = 4;
  localparam int unsigned MEAN_MUL   = 41;
  localparam int unsigned MEAN_SHIFT = 10;

  // 5x5 window, row-major, p33 is the centre pixel
  typedef struct packed {
    logic [PIX_W-1:0] p11, p12, p13, p14, p15;
    logic [PIX_W-1:0] p21, p22, p23, p24, p25;
    logic [PIX_W-1:0] p31, p32, p33, p34, p35;
    logic [PIX_W-1:0] p41, p42, p43, p44, p45;
    logic [PIX_W-1:0] p51, p52, p53, p54, p55;
  } window_t;

  // a - b clamped at zero
  function automatic logic [PIX_W-1:0] sat_sub(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a > b) ? PIX_W'(a - b) : '0;
  endfunction

endpackage

// File: rtl/region_binarize_5x5_if.sv
// Window stream from the matrix generator and the binarized pixel stream out.
interface region_binarize_5x5_if;
  import region_bin_pkg::*;

  logic             matrix_img_vsync;
  logic             matrix_img_href;
  logic             matrix_top_edge_flag;
  logic             matrix_bottom_edge_flag;
  logic             matrix_left_edge_flag;
  logic             matrix_right_edge_flag;
  window_t          matrix_win;

  logic             post_img_vsync;
  logic             post_img_href;
  logic             post_img_bit;
  logic [PIX_W-1:0] post_img_gray;

  modport master (
    output matrix_img_vsync, matrix_img_href,
    output matrix_top_edge_flag, matrix_bottom_edge_flag,
    output matrix_left_edge_flag, matrix_right_edge_flag,
    output matrix_win,
    input  post_img_vsync, post_img_href, post_img_bit, post_img_gray
  );

  modport slave (
    input  matrix_img_vsync, matrix_img_href,
    input  matrix_top_edge_flag, matrix_bottom_edge_flag,
    input  matrix_left_edge_flag, matrix_right_edge_flag,
    input  matrix_win,
    output post_img_vsync, post_img_href, post_img_bit, post_img_gray
  );

endinterface

// File: rtl/region_binarize_5x5_sum5.sv
// Registered sum of five 8-bit pixels into an 11-bit result.
module sum5_u8
  import region_bin_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic [PIX_W-1:0] c_i,
  input  logic [PIX_W-1:0] d_i,
  input  logic [PIX_W-1:0] e_i,
  output logic [ROW_W-1:0] sum_o
);

  logic [ROW_W-1:0] sum_d;
  logic [ROW_W-1:0] sum_q;

  // widen before adding so 5*255 cannot overflow
  always_comb begin
    sum_d = ROW_W'(a_i) + ROW_W'(b_i) + ROW_W'(c_i) + ROW_W'(d_i) + ROW_W'(e_i);
  end

  // result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/region_binarize_5x5.sv
// Local-mean binarizer over a 5x5 window with per-frame foreground count.
module region_binarize_5x5
  import region_bin_pkg::*;
#(
  parameter int unsigned IMG_H_DISP = 640,
  parameter int unsigned IMG_V_DISP = 480,
  parameter logic        EDGE_BIT   = 1'b0,
  parameter int unsigned CNT_W      = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PIX_W-1:0]          cfg_offset,
  region_binarize_5x5_if.slave      bus,
  output logic [CNT_W-1:0]          fg_count,
  output logic                      fg_count_valid
);

  localparam longint unsigned PIX_PER_FRAME = longint'(IMG_H_DISP) * longint'(IMG_V_DISP);

  // the counter must hold a full frame of foreground pixels
  if ((64'd1 << CNT_W) <= PIX_PER_FRAME) begin : g_cnt_w_too_small
    $error("CNT_W too small for IMG_H_DISP*IMG_V_DISP");
  end

  window_t          win;
  logic [ROW_W-1:0] row_sum [5];

  logic [PIPE_LAT-1:0] vs_q, hr_q;
  logic                edge_q1, edge_q2, edge_q3;
  logic [PIX_W-1:0]    p33_q1, p33_q2, p33_q3;
  logic [TOT_W-1:0]    total_d2, total_q2;
  logic [PROD_W-1:0]   prod_d3;
  logic [PIX_W-1:0]    mean_d3, thr_d3, thr_q3;
  logic                bit_d4, bit_q4;

  logic                vs_in_q;
  logic [PIX_W-1:0]    offset_d, offset_q;

  logic                post_vs_prev_q;
  logic                post_rise, post_fall;
  logic [CNT_W-1:0]    acc_d, acc_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                valid_d, valid_q;

  assign win = bus.matrix_win;

  // S1: five registered row sums
  sum5_u8 u_row1 (.clk, .rst, .a_i(win.p11), .b_i(win.p12), .c_i(win.p13),
                  .d_i(win.p14), .e_i(win.p15), .sum_o(row_sum[0]));
  sum5_u8 u_row2 (.clk, .rst, .a_i(win.p21), .b_i(win.p22), .c_i(win.p23),
                  .d_i(win.p24), .e_i(win.p25), .sum_o(row_sum[1]));
  sum5_u8 u_row3 (.clk, .rst, .a_i(win.p31), .b_i(win.p32), .c_i(win.p33),
                  .d_i(win.p34), .e_i(win.p35), .sum_o(row_sum[2]));
  sum5_u8 u_row4 (.clk, .rst, .a_i(win.p41), .b_i(win.p42), .c_i(win.p43),
                  .d_i(win.p44), .e_i(win.p45), .sum_o(row_sum[3]));
  sum5_u8 u_row5 (.clk, .rst, .a_i(win.p51), .b_i(win.p52), .c_i(win.p53),
                  .d_i(win.p54), .e_i(win.p55), .sum_o(row_sum[4]));

  // S2..S4 next-state: total, mean/threshold, strict compare with href gating
  always_comb begin
    total_d2 = TOT_W'(row_sum[0]) + TOT_W'(row_sum[1]) + TOT_W'(row_sum[2])
             + TOT_W'(row_sum[3]) + TOT_W'(row_sum[4]);
    prod_d3  = PROD_W'(total_q2) * PROD_W'(MEAN_MUL);
    mean_d3  = PIX_W'(prod_d3 >> MEAN_SHIFT);
    thr_d3   = sat_sub(mean_d3, offset_q);
    bit_d4   = hr_q[PIPE_LAT-2] & (edge_q3 ? EDGE_BIT : (p33_q3 > thr_q3));
  end

  // data path and matched sideband delay lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q     <= '0;
      hr_q     <= '0;
      edge_q1  <= 1'b0;
      edge_q2  <= 1'b0;
      edge_q3  <= 1'b0;
      p33_q1   <= '0;
      p33_q2   <= '0;
      p33_q3   <= '0;
      total_q2 <= '0;
      thr_q3   <= '0;
      bit_q4   <= 1'b0;
    end else begin
      vs_q     <= {vs_q[PIPE_LAT-2:0], bus.matrix_img_vsync};
      hr_q     <= {hr_q[PIPE_LAT-2:0], bus.matrix_img_href};
      edge_q1  <= bus.matrix_top_edge_flag | bus.matrix_bottom_edge_flag
                | bus.matrix_left_edge_flag | bus.matrix_right_edge_flag;
      edge_q2  <= edge_q1;
      edge_q3  <= edge_q2;
      p33_q1   <= win.p33;
      p33_q2   <= p33_q1;
      p33_q3   <= p33_q2;
      total_q2 <= total_d2;
      thr_q3   <= thr_d3;
      bit_q4   <= bit_d4;
    end
  end

  // offset is captured only at the start of a frame
  always_comb begin
    offset_d = offset_q;
    if (bus.matrix_img_vsync && !vs_in_q) offset_d = cfg_offset;
  end

  // offset register and input vsync history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_in_q  <= 1'b0;
      offset_q <= '0;
    end else begin
      vs_in_q  <= bus.matrix_img_vsync;
      offset_q <= offset_d;
    end
  end

  assign post_rise = vs_q[PIPE_LAT-1] & ~post_vs_prev_q;
  assign post_fall = ~vs_q[PIPE_LAT-1] & post_vs_prev_q;

  // foreground accumulator: clear on frame start wins over increment, saturates
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (post_rise) begin
      acc_d = '0;
    end else if (hr_q[PIPE_LAT-1] && bit_q4 && (acc_q != '1)) begin
      acc_d = acc_q + CNT_W'(1);
    end
    if (post_fall) begin
      cnt_d   = acc_q;
      valid_d = 1'b1;
    end
  end

  // counter state and published count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_vs_prev_q <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      valid_q        <= 1'b0;
    end else begin
      post_vs_prev_q <= vs_q[PIPE_LAT-1];
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      valid_q        <= valid_d;
    end
  end

  assign bus.post_img_vsync = vs_q[PIPE_LAT-1];
  assign bus.post_img_href  = hr_q[PIPE_LAT-1];
  assign bus.post_img_bit   = bit_q4;
  assign bus.post_img_gray  = {PIX_W{bit_q4}};
  assign fg_count           = cnt_q;
  assign fg_count_valid     = valid_q;

endmodule

// File: tb/tb_region_binarize_5x5.sv
// Directed bench for region_binarize_5x5.
module tb_region_binarize_5x5;
  import region_bin_pkg::*;

  localparam int unsigned CNT_W = 20;

  logic             clk;
  logic             rst;
  logic [7:0]       cfg_offset;
  logic [CNT_W-1:0] fg_count;
  logic             fg_count_valid;

  int checks   = 0;
  int failures = 0;

  region_binarize_5x5_if bus ();

  region_binarize_5x5 #(
    .IMG_H_DISP(640), .IMG_V_DISP(480), .EDGE_BIT(1'b0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_offset(cfg_offset), .bus(bus.slave),
    .fg_count(fg_count), .fg_count_valid(fg_count_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input logic [7:0] v, input logic [7:0] c, input logic le);
    bus.matrix_win            = {25{v}};
    bus.matrix_win.p33        = c;
    bus.matrix_left_edge_flag = le;
    bus.matrix_img_href       = 1'b1;
  endtask

  task automatic idle_win();
    bus.matrix_img_href       = 1'b0;
    bus.matrix_left_edge_flag = 1'b0;
  endtask

  // one window, check nothing at 3 clocks and the result at 4 clocks
  task automatic run_win(input string tag, input logic [7:0] v, input logic [7:0] c,
                         input logic le, input logic eb);
    set_win(v, c, le);
    tick();
    idle_win();
    @(posedge clk);
    tick();
    check({tag, "_early_href"}, 32'(bus.post_img_href), 32'd0);
    tick();
    check({tag, "_href"}, 32'(bus.post_img_href), 32'd1);
    check({tag, "_bit"},  32'(bus.post_img_bit), 32'(eb));
    check({tag, "_gray"}, 32'(bus.post_img_gray), eb ? 32'd255 : 32'd0);
  endtask

  task automatic new_frame(input logic [7:0] off);
    bus.matrix_img_vsync = 1'b0;
    idle_win();
    repeat (8) tick();
    cfg_offset           = off;
    bus.matrix_img_vsync = 1'b1;
    repeat (2) tick();
  endtask

  // back-to-back windows; bit i of mask selects a foreground window
  task automatic stream(input logic [31:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      set_win(8'd100, mask[i] ? 8'd100 : 8'd90, 1'b0);
      tick();
    end
    idle_win();
  endtask

  // bounded wait for the end-of-frame count pulse
  task automatic watch(output int pulses, output logic [31:0] cnt);
    pulses = 0;
    cnt    = 32'hFFFF_FFFF;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (fg_count_valid) begin
        pulses++;
        cnt = 32'(fg_count);
      end
    end
  endtask

  int          pulses;
  logic [31:0] cnt;

  initial begin
    rst                         = 1'b1;
    cfg_offset                  = 8'd0;
    bus.matrix_img_vsync        = 1'b0;
    bus.matrix_img_href         = 1'b0;
    bus.matrix_top_edge_flag    = 1'b0;
    bus.matrix_bottom_edge_flag = 1'b0;
    bus.matrix_left_edge_flag   = 1'b0;
    bus.matrix_right_edge_flag  = 1'b0;
    bus.matrix_win              = '0;
    repeat (2) tick();
    check("rst_vsync", 32'(bus.post_img_vsync), 32'd0);
    check("rst_href",  32'(bus.post_img_href),  32'd0);
    check("rst_bit",   32'(bus.post_img_bit),   32'd0);
    check("rst_gray",  32'(bus.post_img_gray),  32'd0);
    check("rst_cnt",   32'(fg_count),           32'd0);
    check("rst_valid", 32'(fg_count_valid),     32'd0);
    rst = 1'b0;

    new_frame(8'd8);
    run_win("u100_off8",  8'd100, 8'd100, 1'b0, 1'b1);
    run_win("p33_90",     8'd100, 8'd90,  1'b0, 1'b0);
    run_win("u255",       8'd255, 8'd255, 1'b0, 1'b1);
    run_win("u0_sat",     8'd0,   8'd0,   1'b0, 1'b0);

    new_frame(8'd0);
    run_win("u100_off0",  8'd100, 8'd100, 1'b0, 1'b0);
    run_win("left_edge",  8'd100, 8'd200, 1'b1, 1'b0);
    cfg_offset = 8'd200;
    run_win("mid_cfg",    8'd100, 8'd90,  1'b0, 1'b0);

    new_frame(8'd200);
    run_win("new_off200", 8'd100, 8'd90,  1'b0, 1'b1);

    // 8x4 frame with 7 foreground windows
    new_frame(8'd8);
    stream(32'h8042_0229, 32);
    repeat (6) tick();
    bus.matrix_img_vsync = 1'b0;
    watch(pulses, cnt);
    check("cnt7_pulses", 32'(pulses), 32'd1);
    check("cnt7_value",  cnt,         32'd7);

    new_frame(8'd8);
    repeat (5) tick();
    bus.matrix_img_vsync = 1'b0;
    watch(pulses, cnt);
    check("empty_pulses", 32'(pulses), 32'd1);
    check("empty_value",  cnt,         32'd0);

    // reset in the middle of a frame
    new_frame(8'd8);
    stream(32'h0000_03FF, 10);
    check("pre_rst_href", 32'(bus.post_img_href), 32'd1);
    rst                  = 1'b1;
    bus.matrix_img_vsync = 1'b0;
    #1;
    check("mid_rst_vsync", 32'(bus.post_img_vsync), 32'd0);
    check("mid_rst_href",  32'(bus.post_img_href),  32'd0);
    check("mid_rst_bit",   32'(bus.post_img_bit),   32'd0);
    check("mid_rst_gray",  32'(bus.post_img_gray),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    watch(pulses, cnt);
    check("abort_pulses", 32'(pulses), 32'd0);

    new_frame(8'd8);
    stream(32'h0000_0421, 12);
    repeat (6) tick();
    bus.matrix_img_vsync = 1'b0;
    watch(pulses, cnt);
    check("after_rst_pulses", 32'(pulses), 32'd1);
    check("after_rst_value",  cnt,         32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/region_binarize_5x5.md
Name: region_binarize_5x5

Overview:
- Consumes the 5x5 8-bit window stream from the matrix generator, with its vsync, href and edge flags, and emits one binarized pixel per valid window.
- A pixel is foreground when the centre pixel exceeds its local 5x5 mean minus a per-frame offset.
- Sits directly downstream of the 5x5 matrix generator and feeds the display/output formatter.
- Also produces a per-frame foreground pixel count for auto-tuning firmware.

Parameters:
- IMG_H_DISP, 640, active pixels per line; used only for sizing the count width.
- IMG_V_DISP, 480, active lines per frame; used only for sizing the count width.
- EDGE_BIT, 1'b0, binary value forced on any window flagged as a frame edge.
- CNT_W, 20, width of fg_count; must satisfy 2^CNT_W > IMG_H_DISP*IMG_V_DISP.

Ports:
- clk  in  1  pixel clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- cfg_offset  in  8  unsigned threshold offset; sampled per frame.
- matrix_img_vsync  in  1  frame valid from the window generator.
- matrix_img_href  in  1  window valid.
- matrix_top_edge_flag  in  1  window touches the top border.
- matrix_bottom_edge_flag  in  1  window touches the bottom border.
- matrix_left_edge_flag  in  1  window touches the left border.
- matrix_right_edge_flag  in  1  window touches the right border.
- matrix_p11 .. matrix_p55  in  8 each  window pixels, 25 ports, row-major; p33 is the centre.
- post_img_vsync  out  1  vsync delayed to align with the data path.
- post_img_href  out  1  href delayed to align with the data path.
- post_img_bit  out  1  binary result.
- post_img_gray  out  8  8'd255 when post_img_bit=1, else 8'd0.
- fg_count  out  CNT_W  foreground count of the last completed frame.
- fg_count_valid  out  1  one-cycle pulse when fg_count updates.

Behaviour:
- Reset (rst=1, asynchronous): every pipeline register and every output goes to 0; offset_reg goes to 0.
- Reset asserted mid-frame discards the partial frame; no fg_count_valid is issued for it.
- offset_reg loads cfg_offset on the rising edge of matrix_img_vsync, so cfg_offset changes inside a frame have no effect until the next frame.
- Pipeline, fixed latency 4 clocks, input to output:
  - S1: five row sums, each 11-bit unsigned. Register p33 and pack the four edge flags as edge_any (OR).
  - S2: total = sum of the five row sums, 13-bit; max 6375.
  - S3: mean = (total*41) >> 10, using a 19-bit product and an 8-bit result. thr = mean - offset_reg, saturating at 0 (8-bit).
  - S4: bit = edge_any ? EDGE_BIT : (p33 > thr). Comparison is strict and unsigned.
- vsync, href and edge_any travel through 4-stage delay lines matched to the data path.
- post_img_bit and post_img_gray are forced to 0 whenever delayed href is 0, whatever the data path holds.
- Data registers advance every clock; there is no back-pressure and no enable. Input is valid exactly when href=1.
- Foreground counter:
  - fg_acc clears on the rising edge of post_img_vsync.
  - fg_acc increments when post_img_href=1 and post_img_bit=1.
  - On the falling edge of post_img_vsync, fg_count <= fg_acc, and fg_count_valid pulses high for one clock on that same cycle.
- fg_acc saturates at all-ones and does not wrap.
- Simultaneous edge and increment: the rising-edge clear has priority over an increment in the same cycle. This cannot occur with legal upstream timing, but the priority is still required.
- A vsync pulse with no href produces fg_count=0 and a valid pulse.

Decomposition:
- Shared package region_bin_pkg holds:
  - MEAN_MUL=41 and MEAN_SHIFT=10;
  - PIPE_LAT=4;
  - the 11/13/19-bit width constants.
- One natural sub-module: sum5_u8, a registered 5-input 8-bit adder giving an 11-bit sum. It is instantiated five times for the row sums in S1.
- The S2 total is a sixth sum at 13 bits, built inline or as a widened variant.

Test Plan:
- Uniform 100 window, offset 8, no edges -> mean 100, thr 92, bit 1, gray 255, appearing 4 clocks after href.
- Window all 100 except p33=90, offset 8 -> total 2490, mean 99, thr 91, bit 0.
- All 255, offset 8 -> mean 255, thr 247, bit 1. Then all 0 -> thr saturates to 0, bit 0. Then uniform 100 with offset 0 -> thr 100, bit 0 (strict compare).
- Uniform 100 with left_edge_flag=1, EDGE_BIT=0 -> bit 0. Change cfg_offset mid-frame to 200 -> results unchanged until the next vsync rise.
- 8x4 frame where exactly 7 windows give bit 1 -> fg_count=7 with one fg_count_valid pulse at post vsync fall. An empty frame then gives fg_count=0.
- Assert rst for 2 clocks mid-frame -> all outputs 0 immediately. The next full frame counts correctly and the aborted frame produces no valid pulse.
